// File: rtl/tlight_conflict_monitor.sv
// -----------------------------------------------------------------------------
// tlight_conflict_monitor
//
// Safety stage between the traffic-light controller and the signal heads.
// The controller lamp codes are registered through to the heads, and each
// sample is checked for:
//   - illegal codes,
//   - conflicting rights-of-way,
//   - green going straight to red (skipped yellow),
//   - yellow held for less than MIN_YEL cycles before red.
// When a fault is detected the monitor latches into all-red flashing. It
// stays there until an operator clear, followed by a sustained all-red
// recovery window.
//
// Lamp code: bit2 = red, bit1 = yellow, bit0 = green.
//
// Ports
//   clk         system clock (1 cycle = 1 s)
//   r           synchronous active-high reset
//   m1_in       controller code, main road 1
//   m2_in       controller code, main road 2
//   mt_in       controller code, main turn
//   s_in        controller code, side road
//   clr_fault   operator fault-clear pulse (acted on only in FAULT)
//   m1          registered lamp drive, main road 1
//   m2          registered lamp drive, main road 2
//   mt          registered lamp drive, main turn
//   s           registered lamp drive, side road
//   fault       high in FAULT and RECOVER
//   fault_code  first-fault cause:
//                 001 illegal, 010 conflict, 100 skip, 011 short yellow
//   flash       high in FAULT
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_MONITOR | normal pass-through with 1-cycle latency, checks active
// ST_FAULT   | lamps flash all-red / all-dark, inputs ignored
// ST_RECOVER | lamps solid red, waiting for RECOVER_CYC all-red samples
// -----------------------------------------------------------------------------
module tlight_conflict_monitor #(
   parameter int MIN_YEL     = 3,
   parameter int FILTER      = 2,
   parameter int FLASH_HALF  = 1,
   parameter int RECOVER_CYC = 4
) (
   input  logic       clk,
   input  logic       r,
   input  logic [2:0] m1_in,
   input  logic [2:0] m2_in,
   input  logic [2:0] mt_in,
   input  logic [2:0] s_in,
   input  logic       clr_fault,
   output logic [2:0] m1,
   output logic [2:0] m2,
   output logic [2:0] mt,
   output logic [2:0] s,
   output logic       fault,
   output logic [2:0] fault_code,
   output logic       flash
);

   localparam logic [2:0] RED  = 3'b100;
   localparam logic [2:0] YEL  = 3'b010;
   localparam logic [2:0] GRN  = 3'b001;
   localparam logic [2:0] DARK = 3'b000;

   localparam logic [2:0] CODE_ILLEGAL  = 3'b001;
   localparam logic [2:0] CODE_CONFLICT = 3'b010;
   localparam logic [2:0] CODE_SHORT    = 3'b011;
   localparam logic [2:0] CODE_SKIP     = 3'b100;

   localparam int FW = (FLASH_HALF  > 1) ? $clog2(FLASH_HALF)  : 1;
   localparam int RW = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC) : 1;

   localparam logic [FW-1:0] FLASH_RELOAD = FW'(FLASH_HALF - 1);
   localparam logic [RW-1:0] REC_LAST     = RW'(RECOVER_CYC - 1);

   localparam logic [11:0] ALL_RED  = {4{RED}};
   localparam logic [11:0] ALL_DARK = {4{DARK}};

   typedef enum logic [1:0] {
      ST_MONITOR,
      ST_FAULT,
      ST_RECOVER
   } state_t;

   state_t          state;
   // Approach index: 0 = m1, 1 = m2, 2 = mt, 3 = s
   logic [3:0][2:0] code_in;
   logic [3:0][2:0] prev_code;
   logic [3:0][3:0] yel_cnt;
   logic [3:0][2:0] lamp;
   logic [3:0]      filt_cnt;
   logic [FW-1:0]   flash_tmr;
   logic            flash_off;
   logic [RW-1:0]   rec_cnt;

   logic            illegal;
   logic            conflict;
   logic            skip;
   logic            short_yel;
   logic            offend;
   logic [3:0]      filt_inc;
   logic            filt_hit;
   logic            latch;
   logic [2:0]      cause;
   logic            all_red;

   function automatic logic is_active(input logic [2:0] c);
      return c[1] | c[0];
   endfunction

   assign code_in = {s_in, mt_in, m2_in, m1_in};
   assign all_red = (code_in == ALL_RED);

   always_comb begin
      illegal   = 1'b0;
      skip      = 1'b0;
      short_yel = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (code_in[i] != RED && code_in[i] != YEL && code_in[i] != GRN)
            illegal = 1'b1;
         if (prev_code[i] == GRN && code_in[i] == RED)
            skip = 1'b1;
         if (prev_code[i] == YEL && code_in[i] == RED && int'(yel_cnt[i]) < MIN_YEL)
            short_yel = 1'b1;
      end
   end

   assign conflict = (is_active(s_in) &
                      (is_active(m1_in) | is_active(m2_in) | is_active(mt_in))) |
                     (mt_in[0] & m2_in[0]);

   // Illegal/conflict samples go through the debounce filter.
   // While they are being filtered they also mask skip/short detection, so a
   // transient glitch can never be reported as a sequencing fault.
   assign offend   = illegal | conflict;
   assign filt_inc = (filt_cnt == 4'hF) ? 4'hF : filt_cnt + 4'd1;
   assign filt_hit = offend && (int'(filt_inc) >= FILTER);
   assign latch    = filt_hit | (!offend & (skip | short_yel));

   always_comb begin
      cause = CODE_SHORT;
      if (illegal)
         cause = CODE_ILLEGAL;
      else if (conflict)
         cause = CODE_CONFLICT;
      else if (skip)
         cause = CODE_SKIP;
   end

   always_ff @(posedge clk) begin
      if (r) begin
         state      <= ST_MONITOR;
         lamp       <= ALL_RED;
         fault      <= 1'b0;
         fault_code <= 3'b000;
         flash      <= 1'b0;
         prev_code  <= ALL_RED;
         yel_cnt    <= '0;
         filt_cnt   <= '0;
         flash_tmr  <= '0;
         flash_off  <= 1'b0;
         rec_cnt    <= '0;
      end else begin
         case (state)
            ST_MONITOR: begin
               if (offend) begin
                  filt_cnt <= filt_inc;
               end else begin
                  filt_cnt  <= '0;
                  // History only advances on clean samples; a masked
                  // sample must not become the baseline for the next one.
                  prev_code <= code_in;
                  for (int i = 0; i < 4; i++) begin
                     if (code_in[i] == YEL)
                        yel_cnt[i] <= (yel_cnt[i] == 4'hF) ? 4'hF : yel_cnt[i] + 4'd1;
                     else
                        yel_cnt[i] <= 4'd0;
                  end
               end

               if (latch) begin
                  state      <= ST_FAULT;
                  fault      <= 1'b1;
                  fault_code <= cause;
                  flash      <= 1'b1;
                  lamp       <= ALL_RED;
                  flash_tmr  <= FLASH_RELOAD;
                  flash_off  <= 1'b0;
               end else if (offend) begin
                  lamp <= ALL_RED;
               end else begin
                  lamp <= code_in;
               end
            end

            ST_FAULT: begin
               if (clr_fault) begin
                  state   <= ST_RECOVER;
                  flash   <= 1'b0;
                  lamp    <= ALL_RED;
                  rec_cnt <= '0;
               end else if (flash_tmr == '0) begin
                  flash_tmr <= FLASH_RELOAD;
                  flash_off <= ~flash_off;
                  lamp      <= flash_off ? ALL_RED : ALL_DARK;
               end else begin
                  flash_tmr <= flash_tmr - 1'b1;
               end
            end

            ST_RECOVER: begin
               lamp <= ALL_RED;
               if (all_red) begin
                  if (rec_cnt == REC_LAST) begin
                     state      <= ST_MONITOR;
                     fault      <= 1'b0;
                     fault_code <= 3'b000;
                     prev_code  <= code_in;
                     yel_cnt    <= '0;
                     filt_cnt   <= '0;
                     rec_cnt    <= '0;
                  end else begin
                     rec_cnt <= rec_cnt + 1'b1;
                  end
               end else begin
                  rec_cnt <= '0;
               end
            end

            default: begin
               state <= ST_MONITOR;
               lamp  <= ALL_RED;
            end
         endcase
      end
   end

   assign m1 = lamp[0];
   assign m2 = lamp[1];
   assign mt = lamp[2];
   assign s  = lamp[3];

endmodule

// File: tb/tb_tlight_conflict_monitor.sv
module tb_tlight_conflict_monitor;

   localparam int MIN_YEL     = 3;
   localparam int FILTER      = 2;
   localparam int FLASH_HALF  = 1;
   localparam int RECOVER_CYC = 4;

   localparam logic [2:0] R = 3'b100;
   localparam logic [2:0] Y = 3'b010;
   localparam logic [2:0] G = 3'b001;
   localparam logic [2:0] D = 3'b000;

   logic       clk = 1'b0;
   logic       r = 1'b1;
   logic       clr_fault = 1'b0;
   logic [2:0] m1_in = 3'b100;
   logic [2:0] m2_in = 3'b100;
   logic [2:0] mt_in = 3'b100;
   logic [2:0] s_in = 3'b100;
   logic [2:0] m1, m2, mt, s, fault_code;
   logic       fault, flash;

   int checks = 0;
   int failures = 0;

   tlight_conflict_monitor #(
      .MIN_YEL(MIN_YEL), .FILTER(FILTER),
      .FLASH_HALF(FLASH_HALF), .RECOVER_CYC(RECOVER_CYC)
   ) dut (
      .clk(clk), .r(r),
      .m1_in(m1_in), .m2_in(m2_in), .mt_in(mt_in), .s_in(s_in),
      .clr_fault(clr_fault),
      .m1(m1), .m2(m2), .mt(mt), .s(s),
      .fault(fault), .fault_code(fault_code), .flash(flash)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // ---------------- behavioural reference model ----------------
   // mode: 0 monitoring, 1 flashing fault, 2 recovering
   int         md;
   logic [2:0] prv [4];
   int         yrun [4];
   int         bad_run;
   int         age;
   int         clean_run;
   logic [2:0] e_lamp [4];
   logic       e_fault, e_flash;
   logic [2:0] e_code;

   function automatic bit is_legal(input logic [2:0] c);
      return (c == R) || (c == Y) || (c == G);
   endfunction

   function automatic bit lit(input logic [2:0] c);
      return (c == Y) || (c == G) || !is_legal(c);
   endfunction

   task automatic enter_fault(input logic [2:0] c);
      md = 1; age = 0;
      e_fault = 1'b1; e_code = c; e_flash = 1'b1;
      foreach (e_lamp[i]) e_lamp[i] = R;
   endtask

   task automatic model_edge();
      logic [2:0] cin [4];
      bit ill, conf, skp, sht, allr;
      cin = '{m1_in, m2_in, mt_in, s_in};
      if (r) begin
         md = 0; bad_run = 0; age = 0; clean_run = 0;
         e_fault = 1'b0; e_code = 3'b000; e_flash = 1'b0;
         foreach (prv[i]) begin prv[i] = R; yrun[i] = 0; e_lamp[i] = R; end
         return;
      end
      if (md == 0) begin
         ill = 0; skp = 0; sht = 0;
         foreach (cin[i]) begin
            if (!is_legal(cin[i])) ill = 1;
            if (prv[i] == G && cin[i] == R) skp = 1;
            if (prv[i] == Y && cin[i] == R && yrun[i] < MIN_YEL) sht = 1;
         end
         conf = (lit(cin[3]) && (lit(cin[0]) || lit(cin[1]) || lit(cin[2]))) ||
                (cin[2] == G && cin[1] == G);
         if (ill || conf) begin
            bad_run = (bad_run < 15) ? bad_run + 1 : 15;
            if (bad_run >= FILTER) enter_fault(ill ? 3'b001 : 3'b010);
            else foreach (e_lamp[i]) e_lamp[i] = R;
         end else begin
            bad_run = 0;
            if (skp) enter_fault(3'b100);
            else if (sht) enter_fault(3'b011);
            else foreach (e_lamp[i]) e_lamp[i] = cin[i];
            foreach (cin[i]) begin
               yrun[i] = (cin[i] == Y) ? ((yrun[i] < 15) ? yrun[i] + 1 : 15) : 0;
               prv[i]  = cin[i];
            end
         end
      end else if (md == 1) begin
         if (clr_fault) begin
            md = 2; clean_run = 0; e_flash = 1'b0;
            foreach (e_lamp[i]) e_lamp[i] = R;
         end else begin
            age++;
            foreach (e_lamp[i]) e_lamp[i] = (((age / FLASH_HALF) % 2) == 1) ? D : R;
         end
      end else begin
         foreach (e_lamp[i]) e_lamp[i] = R;
         allr = 1;
         foreach (cin[i]) if (cin[i] != R) allr = 0;
         if (allr) begin
            clean_run++;
            if (clean_run >= RECOVER_CYC) begin
               md = 0; clean_run = 0; bad_run = 0;
               e_fault = 1'b0; e_code = 3'b000;
               foreach (prv[i]) begin prv[i] = cin[i]; yrun[i] = 0; end
            end
         end else begin
            clean_run = 0;
         end
      end
   endtask

   function automatic logic [16:0] exp_vec();
      return {e_fault, e_code, e_flash, e_lamp[0], e_lamp[1], e_lamp[2], e_lamp[3]};
   endfunction

   function automatic logic [16:0] dut_vec();
      return {fault, fault_code, flash, m1, m2, mt, s};
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic drive(input logic [2:0] a, input logic [2:0] b,
                        input logic [2:0] c, input logic [2:0] d);
      m1_in = a; m2_in = b; mt_in = c; s_in = d;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic apply_reset();
      r = 1'b1; clr_fault = 1'b0;
      drive(R, R, R, R);
      tick();
      r = 1'b0;
   endtask

   function automatic logic [2:0] pick_code();
      if ($urandom_range(0, 9) < 8) begin
         case ($urandom_range(0, 2))
            0: return R;
            1: return Y;
            default: return G;
         endcase
      end
      return 3'($urandom_range(0, 7));
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      r = 1'b1; clr_fault = 1'b1;
      drive(G, Y, D, 3'b111);
      tick();
      r = 1'b0; clr_fault = 1'b0;
      checks++;
      if (dut_vec() !== exp_vec()) begin
         failures++;
         $display("FAIL reset_model: got %h expected %h", dut_vec(), exp_vec());
      end
      checks++;
      if (dut_vec() !== {1'b0, 3'b000, 1'b0, R, R, R, R}) begin
         failures++;
         $display("FAIL reset_state: got %h expected %h", dut_vec(),
                  {1'b0, 3'b000, 1'b0, R, R, R, R});
      end
   endtask

   task automatic test_legal_sequence();
      logic [11:0] seq [9];
      apply_reset();
      seq = '{{G, G, R, R}, {G, G, R, R}, {Y, Y, R, R}, {Y, Y, R, R}, {Y, Y, R, R},
              {R, R, R, R}, {R, R, R, G}, {R, R, R, G}, {R, R, R, Y}};
      for (int i = 0; i < 9; i++) begin
         drive(seq[i][11:9], seq[i][8:6], seq[i][5:3], seq[i][2:0]);
         tick();
         checks++;
         if (dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL legal_model[%0d]: got %h expected %h", i, dut_vec(), exp_vec());
         end
         checks++;
         if ({fault, m1, m2, mt, s} !== {1'b0, seq[i]}) begin
            failures++;
            $display("FAIL legal_latency[%0d]: got %h expected %h", i,
                     {fault, m1, m2, mt, s}, {1'b0, seq[i]});
         end
      end
   endtask

   task automatic test_short_yellow();
      apply_reset();
      drive(G, R, R, R); tick();
      drive(Y, R, R, R); tick();
      tick();
      drive(R, R, R, R); tick();
      checks++;
      if (dut_vec() !== {1'b1, 3'b011, 1'b1, R, R, R, R}) begin
         failures++;
         $display("FAIL short_latch: got %h expected %h", dut_vec(),
                  {1'b1, 3'b011, 1'b1, R, R, R, R});
      end
      tick();
      checks++;
      if (dut_vec() !== {1'b1, 3'b011, 1'b1, D, D, D, D}) begin
         failures++;
         $display("FAIL short_dark: got %h expected %h", dut_vec(),
                  {1'b1, 3'b011, 1'b1, D, D, D, D});
      end
   endtask

   task automatic test_conflict_filter();
      apply_reset();
      drive(G, R, R, R); tick();
      drive(G, R, R, G); tick();
      checks++;
      if (dut_vec() !== {1'b0, 3'b000, 1'b0, R, R, R, R}) begin
         failures++;
         $display("FAIL conflict_mask: got %h expected %h", dut_vec(),
                  {1'b0, 3'b000, 1'b0, R, R, R, R});
      end
      drive(G, R, R, R); tick();
      checks++;
      if (dut_vec() !== {1'b0, 3'b000, 1'b0, G, R, R, R}) begin
         failures++;
         $display("FAIL conflict_resume: got %h expected %h", dut_vec(),
                  {1'b0, 3'b000, 1'b0, G, R, R, R});
      end
      drive(G, R, R, G); tick();
      checks++;
      if (fault !== 1'b0) begin
         failures++;
         $display("FAIL conflict_first: got %b expected 0", fault);
      end
      tick();
      checks++;
      if (dut_vec() !== {1'b1, 3'b010, 1'b1, R, R, R, R}) begin
         failures++;
         $display("FAIL conflict_latch: got %h expected %h", dut_vec(),
                  {1'b1, 3'b010, 1'b1, R, R, R, R});
      end
   endtask

   task automatic test_illegal();
      apply_reset();
      drive(R, G, R, R); tick();
      drive(R, R, 3'b011, R); tick();
      checks++;
      if ({fault, m1, m2, mt, s} !== {1'b0, R, R, R, R}) begin
         failures++;
         $display("FAIL illegal_mask: got %h expected %h", {fault, m1, m2, mt, s},
                  {1'b0, R, R, R, R});
      end
      tick();
      checks++;
      if ({fault, fault_code, flash} !== {1'b1, 3'b001, 1'b1}) begin
         failures++;
         $display("FAIL illegal_code: got %b expected 10011", {fault, fault_code, flash});
      end
   endtask

   // Starts in the FAULT state left by test_illegal.
   task automatic test_recovery();
      drive(G, G, G, G);
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if ({m1, m2, mt, s} !== ((i % 2 == 0) ? {D, D, D, D} : {R, R, R, R})) begin
            failures++;
            $display("FAIL flash_phase[%0d]: got %h", i, {m1, m2, mt, s});
         end
      end
      clr_fault = 1'b1; drive(R, R, R, R); tick();
      clr_fault = 1'b0;
      checks++;
      if (dut_vec() !== {1'b1, 3'b001, 1'b0, R, R, R, R}) begin
         failures++;
         $display("FAIL recover_enter: got %h expected %h", dut_vec(),
                  {1'b1, 3'b001, 1'b0, R, R, R, R});
      end
      for (int i = 0; i < 8; i++) begin
         if (i == 3) drive(R, Y, R, R); else drive(R, R, R, R);
         tick();
         checks++;
         if (dut_vec() !== ((i == 7) ? {1'b0, 3'b000, 1'b0, R, R, R, R}
                                     : {1'b1, 3'b001, 1'b0, R, R, R, R})) begin
            failures++;
            $display("FAIL recover_step[%0d]: got %h", i, dut_vec());
         end
      end
      drive(R, G, R, R); tick();
      checks++;
      if (dut_vec() !== {1'b0, 3'b000, 1'b0, R, G, R, R}) begin
         failures++;
         $display("FAIL recover_resume: got %h", dut_vec());
      end
   endtask

   task automatic test_mid_fault_reset();
      apply_reset();
      drive(G, R, R, G); tick(); tick(); tick();
      checks++;
      if (fault !== 1'b1) begin
         failures++;
         $display("FAIL midreset_pre: got %b expected 1", fault);
      end
      r = 1'b1; clr_fault = 1'b1; tick();
      r = 1'b0; clr_fault = 1'b0;
      checks++;
      if (dut_vec() !== {1'b0, 3'b000, 1'b0, R, R, R, R}) begin
         failures++;
         $display("FAIL midreset_state: got %h", dut_vec());
      end
      drive(R, R, G, R); tick();
      checks++;
      if (dut_vec() !== {1'b0, 3'b000, 1'b0, R, R, G, R}) begin
         failures++;
         $display("FAIL midreset_monitor: got %h", dut_vec());
      end
   endtask

   task automatic test_random();
      int n = 0;
      apply_reset();
      while (n < 4000) begin
         int kind = $urandom_range(0, 3);
         int len  = $urandom_range(1, 8);
         for (int k = 0; k < len; k++) begin
            r         = ($urandom_range(0, 299) == 0);
            clr_fault = ($urandom_range(0, 7) == 0);
            case (kind)
               0: drive(R, R, R, R);
               1: drive(pick_code(), pick_code(), R, R);
               2: drive(R, R, R, pick_code());
               default: drive(pick_code(), pick_code(), pick_code(), pick_code());
            endcase
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
               failures++;
               $display("FAIL random[%0d]: got %h expected %h", n, dut_vec(), exp_vec());
            end
            n++;
         end
      end
      r = 1'b0; clr_fault = 1'b0;
   endtask

   initial begin
      test_reset();
      test_legal_sequence();
      test_short_yellow();
      test_conflict_filter();
      test_illegal();
      test_recovery();
      test_mid_fault_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tlight_conflict_monitor.md
Name: tlight_conflict_monitor

Overview:
- Safety stage directly downstream of the trafic_light controller.
- Consumes its four 3-bit lamp codes (m1, m2, mt, s) and checks them for illegal codes, conflicting rights-of-way and bad amber sequencing.
- Drives the registered lamp outputs to the signal heads.
- On a detected fault, latches into all-red flashing mode until an operator clear plus a sustained all-red recovery window.

Parameters:
- MIN_YEL, 3: minimum consecutive cycles of yellow required before red (1 cycle = 1 s at system clock).
- FILTER, 2: consecutive offending samples required to latch an illegal or conflict fault (range 1..15).
- FLASH_HALF, 1: cycles per half-period of fault flashing.
- RECOVER_CYC, 4: consecutive all-red input cycles required in RECOVER before returning to MONITOR.

Ports:
- clk  in  1  system clock.
- r  in  1  reset, synchronous, active-high.
- m1_in  in  3  controller main road 1 code {R,Y,G}.
- m2_in  in  3  controller main road 2 code.
- mt_in  in  3  controller main turn code.
- s_in  in  3  controller side road code.
- clr_fault  in  1  operator fault-clear pulse.
- m1  out  3  lamp drive, main 1.
- m2  out  3  lamp drive, main 2.
- mt  out  3  lamp drive, main turn.
- s  out  3  lamp drive, side.
- fault  out  1  fault latched (FAULT or RECOVER state).
- fault_code  out  3  first-fault cause.
- flash  out  1  high in FAULT state.

Behaviour:
- Encoding: bit2 = red, bit1 = yellow, bit0 = green. Legal codes are 100, 010 and 001 only. "Active" means yellow or green.
- Reset, on the edge with r = 1:
  - m1, m2, mt, s = 100.
  - fault = 0, fault_code = 000, flash = 0.
  - State = MONITOR.
  - Per-approach previous-code registers = 100; yellow counters = 0; filter counter = 0; flash and recover counters = 0.
  - r overrides everything, including mid-FAULT and mid-RECOVER.
- All outputs are registered. In MONITOR, outputs equal the inputs sampled on the previous edge (1-cycle latency).
- Illegal fault (code 001): any input code not in {100, 010, 001}.
- Conflict fault (code 010), either of:
  - s active while any of m1, m2, mt is active;
  - mt green while m2 green.
- Skip-yellow fault (code 100): an approach changes green to red directly. Detected from the previous-code register.
- Short-yellow fault (code 011): an approach changes yellow to red with its yellow counter < MIN_YEL.
  - The yellow counter counts consecutive yellow samples, saturates at 15, and clears on any non-yellow sample.
- Fault priority when several are seen on one sample: illegal > conflict > skip > short yellow.
- Illegal and conflict faults are filtered:
  - The filter counter increments on each offending sample and clears on any clean sample.
  - While it is nonzero and below FILTER, that sample's outputs are forced to 100 on all four approaches.
  - The sample on which the count reaches FILTER latches the fault.
- Skip and short-yellow faults latch on the same sample that shows them.
- Latch action on that edge:
  - State → FAULT, fault = 1, fault_code = cause, flash = 1.
  - Outputs = 100 on all approaches; the offending pattern never reaches the lamps.
- FAULT state:
  - Outputs alternate between all-100 and all-000 every FLASH_HALF cycles, starting with 100 on the entry edge.
  - Inputs are ignored.
  - clr_fault = 1 → RECOVER on the next edge.
- RECOVER state:
  - Outputs solid 100, flash = 0, fault stays 1.
  - Recover counter increments on each sample where all four inputs = 100; any other sample clears it.
  - On reaching RECOVER_CYC → MONITOR, with fault = 0, fault_code = 000, and previous-code registers and yellow counters reloaded from the current inputs (all 100).
- clr_fault is ignored in MONITOR and RECOVER.
- The first cause is held; later faults never overwrite fault_code.
- Simultaneous clr_fault and r: reset wins.

Test Plan:
- Legal sequence:
  - Stimulus: m1_in = m2_in = 001, s_in = mt_in = 100; then m1/m2 go 010 for 3 cycles, then 100; s_in then goes 001.
  - Required: outputs track the inputs with 1-cycle latency; fault stays 0 throughout.
- Short yellow:
  - Stimulus: m1_in 001 → 010 for 2 cycles → 100.
  - Required: the edge sampling 100 sets fault = 1, fault_code = 011, flash = 1, all outputs 100; the next edge gives all 000.
- Conflict filtering:
  - Stimulus: s_in = 001 with m1_in = 001 for 1 cycle, then clean.
  - Required: one all-red output cycle, then pass-through resumes; fault = 0.
  - Stimulus: the same conflict held for 2 cycles.
  - Required: fault_code = 010 latched on the 2nd sample.
- Illegal code:
  - Stimulus: mt_in = 011 for 2 cycles.
  - Required: fault_code = 001; a simultaneous skip-yellow on m2 is not reported.
- Recovery:
  - Stimulus: in FAULT, pulse clr_fault; drive all inputs 100 for 3 cycles, one 010 glitch, then 4 cycles of 100.
  - Required: solid red with flash = 0 in RECOVER; return to MONITOR only after the 4th clean cycle following the glitch; fault and fault_code then clear.
- Mid-fault reset:
  - Stimulus: assert r for 1 cycle while in FAULT.
  - Required: next edge gives outputs 100, fault = 0, fault_code = 000, flash = 0, state MONITOR.
